// File: rtl/vga_frame_reader.sv
// Display-side reader: generates 640x480@60 VGA timing and fetches upscaled pixels from the frame RAM.
// Latency: counter state at cycle t appears on vga_* at cycle t+3 (RAM read adds one of those clocks).
// Backpressure: none; free-running, never stalls, no handshake with the RAM writer (tearing allowed).
module vga_frame_reader #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int AW          = 15,
    parameter int DW          = 8,
    parameter logic [DW-1:0] BG_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    output logic [AW-1:0] addr_out,
    output logic          regread,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic [DW-1:0] vga_rgb,
    output logic          frame_start
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [HW-1:0] IMG_W_H = HW'(IMG_W);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [VW-1:0] IMG_H_V = VW'(IMG_H);
    localparam logic [AW-1:0] IMG_W_A = AW'(IMG_W);

    // S0: raster counters and decode
    logic [HW-1:0] h_q, h_d, x0;
    logic [VW-1:0] v_q, v_d, y0;
    logic          vis0, img0, hs0, vs0, fs0;
    logic [AW-1:0] addr0;

    // S1: RAM request plus delayed control
    logic [AW-1:0] addr_q;
    logic          rd_q, vis1_q, img1_q, hs1_q, vs1_q, fs1_q;

    // S2: control waiting for RAM data
    logic          vis2_q, img2_q, hs2_q, vs2_q, fs2_q;

    // S3: registered VGA outputs
    logic [DW-1:0] rgb_q;
    logic          hs3_q, vs3_q, fs3_q;

    // Counter next-state and S0 decode of position, sync windows and RAM address
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        x0    = h_q >> SCALE_SHIFT;
        y0    = v_q >> SCALE_SHIFT;
        vis0  = (h_q < H_VIS_C) && (v_q < V_VIS_C);
        img0  = vis0 && (x0 < IMG_W_H) && (y0 < IMG_H_V);
        hs0   = !((h_q >= HS_BEG) && (h_q < HS_END));
        vs0   = !((v_q >= VS_BEG) && (v_q < VS_END));
        fs0   = (h_q == '0) && (v_q == '0);
        // constant multiply by the stored image width
        addr0 = AW'(y0) * IMG_W_A + AW'(x0);
    end

    // Raster position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // S1: issue RAM read; address holds outside the image so the bus stays quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            rd_q   <= 1'b0;
            vis1_q <= 1'b0;
            img1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            fs1_q  <= 1'b0;
        end else begin
            if (img0) begin
                addr_q <= addr0;
            end
            rd_q   <= img0;
            vis1_q <= vis0;
            img1_q <= img0;
            hs1_q  <= hs0;
            vs1_q  <= vs0;
            fs1_q  <= fs0;
        end
    end

    // S2: carry control across the one-clock RAM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis2_q <= 1'b0;
            img2_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            fs2_q  <= 1'b0;
        end else begin
            vis2_q <= vis1_q;
            img2_q <= img1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            fs2_q  <= fs1_q;
        end
    end

    // S3: select image / background / blank and register syncs alongside the pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            hs3_q <= 1'b1;
            vs3_q <= 1'b1;
            fs3_q <= 1'b0;
        end else begin
            rgb_q <= img2_q ? data_in : (vis2_q ? BG_COLOR : '0);
            hs3_q <= hs2_q;
            vs3_q <= vs2_q;
            fs3_q <= fs2_q;
        end
    end

    assign addr_out    = addr_q;
    assign regread     = rd_q;
    assign vga_rgb     = rgb_q;
    assign vga_hsync   = hs3_q;
    assign vga_vsync   = vs3_q;
    assign frame_start = fs3_q;
endmodule
